seven_seg_scan_scheduler: RTL

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Takes a 16-bit hex value plus per-digit decimal-point and enable masks.
- Sequences the digits at a parameterised refresh rate, inserting an anti-ghosting blank interval before each digit.
- Latches the inputs only at frame boundaries, so a displayed frame never tears.
- Replaces ad-hoc counter-driven anode stepping between the value source and the display pins.

---
 rtl/seven_seg_scan_scheduler.sv | 86 ++++++++
 1 files changed

// File: rtl/seven_seg_scan_scheduler.sv
// seven_seg_scan_scheduler: frame-latched 4-digit seven-segment scan with anti-ghosting blank
module seven_seg_scan_scheduler #(
  parameter int TICK_DIV     = 24999,
  parameter int BLANK_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int BW = BLANK_CYCLES > 0 ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t         state, state_nxt;
  logic [DW-1:0]  div;
  logic [1:0]     idx, idx_nxt;
  logic [BW-1:0]  blank_cnt, blank_nxt;
  logic [15:0]    sh_value, sh_value_nxt;
  logic [3:0]     sh_dp, sh_dp_nxt, sh_en, sh_en_nxt;
  logic           sh_lz, sh_lz_nxt;
  logic           tick, latch, lit, dp_nxt;
  logic [3:0]     nib, an_nxt;
  logic [6:0]     seg_nxt;
  assign tick  = div == DW'(TICK_DIV);
  assign latch = tick && idx == 2'd3;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div        <= '0;
      idx        <= 2'd3;
      state      <= BLANK;
      blank_cnt  <= BW'(BLANK_CYCLES);
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      sh_lz      <= 1'b0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      div        <= tick ? '0 : div + DW'(1);
      idx        <= idx_nxt;
      state      <= state_nxt;
      blank_cnt  <= blank_nxt;
      sh_value   <= sh_value_nxt;
      sh_dp      <= sh_dp_nxt;
      sh_en      <= sh_en_nxt;
      sh_lz      <= sh_lz_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= latch;
    end
  end
  // Leaving BLANK one count early keeps the registered outputs dark for exactly BLANK_CYCLES cycles.
  always_comb begin
    idx_nxt      = tick ? idx + 2'd1 : idx;
    state_nxt    = tick ? (BLANK_CYCLES == 0 ? DRIVE : BLANK)
                 : (state == BLANK && blank_cnt <= BW'(1)) ? DRIVE : state;
    blank_nxt    = tick ? BW'(BLANK_CYCLES) : blank_cnt != '0 ? blank_cnt - BW'(1) : blank_cnt;
    sh_value_nxt = latch ? value    : sh_value;
    sh_dp_nxt    = latch ? dp_in    : sh_dp;
    sh_en_nxt    = latch ? digit_en : sh_en;
    sh_lz_nxt    = latch ? lz_en    : sh_lz;
  end
  always_comb begin
    nib     = sh_value_nxt[{idx_nxt, 2'b00} +: 4];
    lit     = state_nxt == DRIVE && sh_en_nxt[idx_nxt]
              && !(sh_lz_nxt && idx_nxt != 2'd0 && (sh_value_nxt >> {idx_nxt, 2'b00}) == 16'd0);
    an_nxt  = lit ? ~(4'b0001 << idx_nxt) : 4'hF;
    seg_nxt = lit ? HEX[nib] : 7'h7F;
    dp_nxt  = lit ? ~sh_dp_nxt[idx_nxt] : 1'b1;
  end
endmodule
